eq_compare_arbiter: RTL and testbench
=====================================

EQ_COMPARE_ARBITER -- requirements
Module: eq_compare_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4; number of requesters, 2..8.
REQ-002 SHALL have parameter SLICE_W, default 16; compare slice width; 64 SHALL be an integer multiple of it.
REQ-003 SHALL have port clk, input, 1; single clock, all state on rising edge.
REQ-004 SHALL have port rst, input, 1; synchronous, active-high reset.
REQ-005 SHALL have port req_valid, input, NREQ; per-requester compare request.
REQ-006 SHALL have port req_ready, output, NREQ; one-hot grant/accept strobe.
REQ-007 SHALL have port req_a, input, NREQ*64; operand A, requester i at bits [64i+63:64i].
REQ-008 SHALL have port req_b, input, NREQ*64; operand B, same packing.
REQ-009 SHALL have port rsp_valid, output, 1; result available.
REQ-010 SHALL have port rsp_ready, input, 1; consumer accepts result.
REQ-011 SHALL have port rsp_id, output, clog2(NREQ); index of the served requester.
REQ-012 SHALL have port rsp_eq, output, 1; 1 if A == B over all 64 bits.
REQ-013 SHALL have port busy, output, 1; high in any state other than IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, CMP, RESP.
REQ-015 In IDLE with any req_valid set, SHALL assert req_ready for exactly one requester in that cycle, chosen round-robin: first valid index after last_grant, wrapping modulo NREQ.
REQ-016 On the accept edge, SHALL latch that requester's A, B and index, set slice index k=0, set eq_acc=1, update last_grant, and go to CMP.
REQ-017 req_ready SHALL be all-zero outside IDLE and in IDLE when req_valid is zero.
REQ-018 In CMP, SHALL compare slice k (bits [k*SLICE_W +: SLICE_W]) each cycle, AND the result into eq_acc, and increment k.
REQ-019 After the last slice (k = 64/SLICE_W-1), SHALL go to RESP; default latency from accept edge to rsp_valid is 64/SLICE_W+1 cycles (5 at defaults).
REQ-020 In RESP, SHALL hold rsp_valid=1 with stable rsp_id and rsp_eq until rsp_valid && rsp_ready, then return to IDLE.
REQ-021 The next grant SHALL NOT occur in the same cycle as response acceptance; the earliest new accept is the cycle after return to IDLE.
REQ-022 Requester inputs SHALL be ignored after the accept edge; operand changes during CMP SHALL NOT affect the result.
REQ-023 A requester dropping req_valid before grant SHALL simply not be granted; no state is kept for it.
REQ-024 rsp_id and rsp_eq SHALL be don't-care while rsp_valid=0, but SHALL be driven from registers (no X).

Reset
REQ-025 On rst=1 at a clock edge, SHALL enter IDLE, with rsp_valid=0, rsp_eq=0, rsp_id=0, k=0, eq_acc=0, req_ready=0 and last_grant=NREQ-1 (requester 0 has first priority).
REQ-026 Reset mid-operation (CMP or RESP) SHALL abandon the transaction without emitting a response; the abandoned requester is not re-served automatically.
REQ-027 req_ready SHALL be 0 in any cycle where rst=1.

Configuration
REQ-028 Macro EQ_EARLY_EXIT_EN: when defined, a mismatching slice in CMP SHALL go directly to RESP on the next edge with rsp_eq=0; latency is k+2 cycles from the accept edge, where k is the first mismatching slice.
REQ-029 When EQ_EARLY_EXIT_EN is undefined, all 64/SLICE_W slices SHALL always be evaluated; latency is fixed per REQ-019.

Verification
REQ-030 After reset, req_valid=4'b0001 with A=B=64'hDEAD_BEEF_0123_4567 and rsp_ready=1 -> req_ready=4'b0001 in the same cycle; rsp_valid 5 cycles later with rsp_id=0 and rsp_eq=1.
REQ-031 A=64'h0, B=64'h1 with EQ_EARLY_EXIT_EN defined -> rsp_eq=0 and rsp_valid 2 cycles after accept; without the macro -> rsp_eq=0 at 5 cycles.
REQ-032 A=64'h0, B=64'h8000_0000_0000_0000 -> rsp_eq=0 at 5 cycles in both configurations.
REQ-033 req_valid=4'b1111 held with rsp_ready=1 -> grant order 0,1,2,3,0; no requester is granted twice before all others are served.
REQ-034 rsp_ready=0 for 10 cycles in RESP -> rsp_valid, rsp_id and rsp_eq stay stable, req_ready=0, and no new grant until one cycle after rsp_ready=1.
REQ-035 rst pulsed during CMP slice 2 -> no rsp_valid follows, state is IDLE, and the next grant with req_valid=4'b1111 goes to requester 0.

Source files
------------

// File: rtl/eq_compare_arbiter.sv
// Round-robin arbiter feeding a sliced 64-bit equality comparator with a held response.
// Optional EQ_EARLY_EXIT_EN: stop comparing at the first mismatching slice.
module eq_compare_arbiter #(
    parameter int NREQ    = 4,
    parameter int SLICE_W = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ*64-1:0]        req_a,
    input  logic [NREQ*64-1:0]        req_b,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [$clog2(NREQ)-1:0]   rsp_id,
    output logic                      rsp_eq,
    output logic                      busy
);

    localparam int ID_W   = $clog2(NREQ);
    localparam int NSLICE = 64 / SLICE_W;
    localparam int K_W    = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [K_W-1:0] K_LAST = K_W'(NSLICE - 1);

    typedef enum logic [1:0] {IDLE, CMP, RESP} state_t;

    state_t          state;
    logic [ID_W-1:0] last_grant;
    logic [ID_W-1:0] grant_idx;
    logic            grant_any;
    logic [63:0]     a_q;
    logic [63:0]     b_q;
    logic [K_W-1:0]  k;
    logic            eq_acc;
    logic            slice_eq;

    // Search starts one past the last grant and wraps modulo NREQ.
    always_comb begin
        logic [ID_W:0]   sum;
        logic [ID_W-1:0] cand;
        grant_any = 1'b0;
        grant_idx = '0;
        sum       = '0;
        cand      = '0;
        for (int i = 1; i <= NREQ; i++) begin
            sum = {1'b0, last_grant} + (ID_W+1)'(i);
            if (sum >= (ID_W+1)'(NREQ))
                sum = sum - (ID_W+1)'(NREQ);
            cand = sum[ID_W-1:0];
            if (!grant_any && req_valid[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
    end

    assign req_ready = (state == IDLE && !rst && grant_any) ? (NREQ'(1) << grant_idx) : '0;
    assign slice_eq  = (a_q[k*SLICE_W +: SLICE_W] == b_q[k*SLICE_W +: SLICE_W]);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            rsp_valid  <= 1'b0;
            rsp_eq     <= 1'b0;
            rsp_id     <= '0;
            k          <= '0;
            eq_acc     <= 1'b0;
            last_grant <= ID_W'(NREQ - 1);
            a_q        <= '0;
            b_q        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        a_q        <= req_a[grant_idx*64 +: 64];
                        b_q        <= req_b[grant_idx*64 +: 64];
                        rsp_id     <= grant_idx;
                        last_grant <= grant_idx;
                        k          <= '0;
                        eq_acc     <= 1'b1;
                        state      <= CMP;
                    end
                end
                CMP: begin
                    eq_acc <= eq_acc & slice_eq;
`ifdef EQ_EARLY_EXIT_EN
                    if (!slice_eq) begin
                        rsp_eq    <= 1'b0;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else
`endif
                    if (k == K_LAST) begin
                        rsp_eq    <= eq_acc & slice_eq;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                RESP: begin
                    // Return to IDLE only; the next grant is decided there a cycle later.
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_eq_compare_arbiter.sv
// Self-checking bench for eq_compare_arbiter: vector table, hand sequences, random vs. model.
module tb_eq_compare_arbiter;

    localparam int NREQ = 4;
    localparam int SLICE_W = 16;
    localparam int NSLICE = 64 / SLICE_W;

    logic            clk = 1'b0;
    logic            rst;
    logic [3:0]      req_valid;
    logic [3:0]      req_ready;
    logic [255:0]    req_a;
    logic [255:0]    req_b;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [1:0]      rsp_id;
    logic            rsp_eq;
    logic            busy;

    int n_checks = 0;
    int n_errors = 0;
    int model_last = NREQ - 1;

    eq_compare_arbiter #(.NREQ(NREQ), .SLICE_W(SLICE_W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_eq(rsp_eq), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  rv;
        logic [63:0] a;
        logic [63:0] b;
        int          id;
        logic        eq;
        int          lat_full;
        int          lat_early;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    function automatic int model_rr(input int last, input logic [3:0] rv);
        for (int i = 1; i <= NREQ; i++)
            if (rv[(last + i) % NREQ]) return (last + i) % NREQ;
        return -1;
    endfunction

    function automatic int model_lat(input logic [63:0] a, input logic [63:0] b);
`ifdef EQ_EARLY_EXIT_EN
        for (int s = 0; s < NSLICE; s++)
            if (((a >> (s * SLICE_W)) & 64'hFFFF) != ((b >> (s * SLICE_W)) & 64'hFFFF))
                return s + 2;
`endif
        return NSLICE + 1;
    endfunction

    // Called at posedge+1 with the DUT idle; returns at posedge+1 with the DUT idle again.
    task automatic txn(input logic [3:0] rv, input logic [255:0] a_all, input logic [255:0] b_all,
                       input int exp_id, input logic exp_eq, input int exp_lat, input int hold);
        int lat;
        bit got;
        req_valid = rv;
        req_a     = a_all;
        req_b     = b_all;
        rsp_ready = (hold == 0);
        @(negedge clk);
        check("grant", req_ready, 4'b0001 << exp_id);
        model_last = exp_id;
        @(posedge clk); #1;
        req_valid = 4'b0000;
        req_a = ~a_all;
        req_b = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        got = 0;
        lat = 0;
        for (int i = 1; i <= 20 && !got; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                got = 1;
                lat = i;
            end else begin
                check("ready_low_cmp", req_ready, 0);
            end
        end
        if (!got) begin
            check("rsp_timeout", 0, 1);
            return;
        end
        check("latency", lat, exp_lat);
        check("rsp_id", rsp_id, exp_id);
        check("rsp_eq", rsp_eq, exp_eq);
        check("busy_resp", busy, 1);
        if (hold > 0) begin
            req_valid = 4'b1111;
            repeat (hold) begin
                @(negedge clk);
                check("hold_valid", rsp_valid, 1);
                check("hold_id", rsp_id, exp_id);
                check("hold_eq", rsp_eq, exp_eq);
                check("hold_no_grant", req_ready, 0);
            end
            @(posedge clk); #1;
            rsp_ready = 1'b1;
            @(negedge clk);
            check("no_grant_on_rsp_accept", req_ready, 0);
            check("valid_at_accept", rsp_valid, 1);
            @(posedge clk); #1;
            req_valid = 4'b0000;
            @(negedge clk);
            check("valid_dropped", rsp_valid, 0);
            check("busy_idle", busy, 0);
            @(posedge clk); #1;
        end else begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int  gcount;
        int  last_gc;
        int  gid;
        logic [63:0] ra, rb;
        logic [255:0] pa, pb;
        logic [3:0] rv;
        int sel, id;

        vecs[0] = '{4'b0001, 64'hDEAD_BEEF_0123_4567, 64'hDEAD_BEEF_0123_4567, 0, 1'b1, 5, 5};
        vecs[1] = '{4'b0001, 64'h0, 64'h1, 0, 1'b0, 5, 2};
        vecs[2] = '{4'b0001, 64'h0, 64'h8000_0000_0000_0000, 0, 1'b0, 5, 5};
        vecs[3] = '{4'b0110, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1, 1'b1, 5, 5};
        vecs[4] = '{4'b0110, 64'h0000_0001_0000_0000, 64'h0, 2, 1'b0, 5, 4};
        vecs[5] = '{4'b1001, 64'h0000_0000_0001_0000, 64'h0, 3, 1'b0, 5, 3};
        vecs[6] = '{4'b1001, 64'h0000_0000_0000_0123, 64'h0000_0000_0000_0123, 0, 1'b1, 5, 5};

        rst = 1'b1;
        req_valid = 4'b1111;
        req_a = '0;
        req_b = '0;
        rsp_ready = 1'b1;
        @(negedge clk);
        check("ready_in_reset", req_ready, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("ready_in_reset2", req_ready, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        req_valid = 4'b0000;
        @(negedge clk);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_eq", rsp_eq, 0);
        check("rst_rsp_id", rsp_id, 0);
        check("rst_busy", busy, 0);
        check("idle_no_req", req_ready, 0);
        @(posedge clk); #1;
        model_last = NREQ - 1;

        foreach (vecs[v]) begin
`ifdef EQ_EARLY_EXIT_EN
            txn(vecs[v].rv, {4{vecs[v].a}}, {4{vecs[v].b}}, vecs[v].id, vecs[v].eq, vecs[v].lat_early, 0);
`else
            txn(vecs[v].rv, {4{vecs[v].a}}, {4{vecs[v].b}}, vecs[v].id, vecs[v].eq, vecs[v].lat_full, 0);
`endif
        end

        // Response held off for 10 cycles.
        txn(4'b0100, {4{64'h1234_5678_9ABC_DEF0}}, {4{64'h1234_5678_9ABC_DEF0}},
            model_rr(model_last, 4'b0100), 1'b1, 5, 10);

        // All requesters held valid: round-robin order and one-cycle gap after each response.
        pa = {4{64'hA5A5_5A5A_0F0F_F0F0}};
        req_a = pa;
        req_b = pa;
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        gcount = 0;
        last_gc = 0;
        for (int c = 0; c < 80 && gcount < 5; c++) begin
            @(negedge clk);
            if (req_ready != 0) begin
                gid = model_rr(model_last, 4'b1111);
                check("rr_grant", req_ready, 4'b0001 << gid);
                check("rr_no_rsp_same_cycle", rsp_valid, 0);
                if (gcount > 0) check("rr_gap", c - last_gc, NSLICE + 2);
                model_last = gid;
                last_gc = c;
                gcount++;
            end
        end
        check("rr_count", gcount, 5);
        @(posedge clk); #1;
        req_valid = 4'b0000;
        for (int c = 0; c < 20 && !rsp_valid; c++) @(negedge clk);
        check("rr_drain_valid", rsp_valid, 1);
        @(posedge clk); #1;
        @(posedge clk); #1;

        // Reset during CMP slice 2.
        req_valid = 4'b0001;
        req_a = {4{64'h1}};
        req_b = {4{64'h1}};
        @(negedge clk);
        check("pre_rst_grant", req_ready, 4'b0001 << model_rr(model_last, 4'b0001));
        @(posedge clk); #1;
        req_valid = 4'b0000;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        req_valid = 4'b1111;
        @(negedge clk);
        check("rst_mid_ready", req_ready, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        req_valid = 4'b0000;
        model_last = NREQ - 1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            check("abandoned_no_rsp", rsp_valid, 0);
            check("abandoned_idle", busy, 0);
        end
        @(posedge clk); #1;
        txn(4'b1111, {4{64'h55}}, {4{64'h55}}, 0, 1'b1, 5, 0);

        // Random transactions against the model.
        for (int t = 0; t < 40; t++) begin
            rv = 4'($urandom_range(1, 15));
            for (int r = 0; r < NREQ; r++) begin
                ra = {$urandom, $urandom};
                sel = $urandom_range(0, 2);
                if (sel == 0) rb = ra;
                else if (sel == 1) rb = ra ^ (64'd1 << $urandom_range(0, 63));
                else rb = {$urandom, $urandom};
                pa[r*64 +: 64] = ra;
                pb[r*64 +: 64] = rb;
            end
            id = model_rr(model_last, rv);
            txn(rv, pa, pb, id, pa[id*64 +: 64] == pb[id*64 +: 64],
                model_lat(pa[id*64 +: 64], pb[id*64 +: 64]), ($urandom_range(0, 4) == 0) ? 3 : 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
